lc3_mem_if: RTL and testbench

LC3_MEM_IF -- requirements
Module: lc3_mem_if

---
 rtl/lc3_pkg.sv | 32 +++
 rtl/lc3_io_regs.sv | 72 +++++++
 rtl/lc3_mem_if.sv | 128 ++++++++++++
 tb/tb_lc3_mem_if.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-interface definitions: FSM states, device map, user base.
package lc3_pkg;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CHAR_W = 8;

  localparam logic [WORD_W-1:0] USER_BASE_DEF = 16'h3000;
  localparam logic [WORD_W-1:0] DEV_BASE      = 16'hFE00;
  localparam logic [WORD_W-1:0] ADDR_KBSR     = 16'hFE00;
  localparam logic [WORD_W-1:0] ADDR_KBDR     = 16'hFE02;
  localparam logic [WORD_W-1:0] ADDR_DSR      = 16'hFE04;
  localparam logic [WORD_W-1:0] ADDR_DDR      = 16'hFE06;
  localparam logic [WORD_W-1:0] ADDR_MCR      = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    DONE     = 2'd2
  } lc3_state_e;

  // One device-register access, presented for the single completion cycle.
  typedef struct packed {
    logic              wr;
    logic              rd;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } lc3_io_req_t;

  function automatic logic is_device(input logic [WORD_W-1:0] addr);
    return (addr == ADDR_KBSR) || (addr == ADDR_KBDR) || (addr == ADDR_DSR) ||
           (addr == ADDR_DDR)  || (addr == ADDR_MCR);
  endfunction
endpackage

// File: rtl/lc3_io_regs.sv
// LC-3 memory-mapped device registers: keyboard, display and machine control.
module lc3_io_regs
  import lc3_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  lc3_io_req_t       io_req,
  input  logic              kbd_valid,
  input  logic [CHAR_W-1:0] kbd_data,
  output logic              ddr_valid,
  output logic [CHAR_W-1:0] ddr_data,
  input  logic              ddr_ready,
  output logic              kb_int,
  output logic              run,
  output logic [WORD_W-1:0] rdata_c
);
  logic              kb_rdy, kb_ie, kb_rdy_n, kb_ie_n;
  logic [CHAR_W-1:0] kbdr;
  logic              kbdr_rd, kb_cap;
  logic [5:0]        unused_wdata;

  assign unused_wdata = io_req.wdata[13:8];

  // A KBDR read wins over a new key; the key is taken on the following cycle.
  assign kbdr_rd = io_req.rd && (io_req.addr == ADDR_KBDR);
  assign kb_cap  = kbd_valid && !kb_rdy && !kbdr_rd;

  always_comb begin
    kb_rdy_n = kb_rdy;
    kb_ie_n  = kb_ie;
    if (kbdr_rd)     kb_rdy_n = 1'b0;
    else if (kb_cap) kb_rdy_n = 1'b1;
    if (io_req.wr && (io_req.addr == ADDR_KBSR)) kb_ie_n = io_req.wdata[14];
  end

  // ddr_valid is stored directly as the complement of DSR[15]; run is MCR[15].
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kb_rdy    <= 1'b0;
      kb_ie     <= 1'b0;
      kbdr      <= '0;
      kb_int    <= 1'b0;
      ddr_valid <= 1'b0;
      ddr_data  <= '0;
      run       <= 1'b1;
    end else begin
      kb_rdy <= kb_rdy_n;
      kb_ie  <= kb_ie_n;
      kb_int <= kb_rdy_n & kb_ie_n;
      if (kb_cap) kbdr <= kbd_data;
      if (io_req.wr && (io_req.addr == ADDR_DDR)) begin
        ddr_data  <= io_req.wdata[CHAR_W-1:0];
        ddr_valid <= 1'b1;
      end else if (ddr_valid && ddr_ready) begin
        ddr_valid <= 1'b0;
      end
      if (io_req.wr && (io_req.addr == ADDR_MCR)) run <= io_req.wdata[15];
    end
  end

  always_comb begin
    rdata_c = '0;
    case (io_req.addr)
      ADDR_KBSR: rdata_c = {kb_rdy, kb_ie, 14'h0000};
      ADDR_KBDR: rdata_c = {8'h00, kbdr};
      ADDR_DSR:  rdata_c = {~ddr_valid, 15'h0000};
      ADDR_DDR:  rdata_c = {8'h00, ddr_data};
      ADDR_MCR:  rdata_c = {run, 15'h0000};
      default:   rdata_c = '0;
    endcase
  end
endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR memory interface with access FSM and device dispatch.
// Define LC3_ACV_EN to enable user-mode access-violation checking.
module lc3_mem_if
  import lc3_pkg::*;
#(
  parameter logic [15:0] USER_BASE = USER_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] DATABUS,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic        GateMDR,
  inout  wire  [15:0] MDRbus_out,
  input  logic        Priv_reg,
  output logic        R,
  output logic        ACV,
  output logic        kb_int,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        ddr_valid,
  output logic [7:0]  ddr_data,
  input  logic        ddr_ready,
  output logic        run
);
  lc3_state_e        state;
  logic [WORD_W-1:0] mar, mdr, io_rdata_c;
  logic              start, dev_sel, acv_hit;
  lc3_io_req_t       io_req;

  assign MDRbus_out = GateMDR ? mdr : 16'bz;
  assign start      = (state == IDLE) && MIO_EN;
  assign dev_sel    = is_device(mar);

`ifdef LC3_ACV_EN
  assign acv_hit = Priv_reg && ((mar < USER_BASE) || (mar >= DEV_BASE));

  always_ff @(posedge clk) begin
    if (!reset_n) ACV <= 1'b0;
    else          ACV <= start && acv_hit;
  end
`else
  logic [16:0] unused_cfg;
  assign unused_cfg = {Priv_reg, USER_BASE};
  assign acv_hit    = 1'b0;
  assign ACV        = 1'b0;
`endif

  // Device accesses complete on the edge that enters DONE.
  always_comb begin
    io_req       = '0;
    io_req.wr    = start && dev_sel && !acv_hit && R_W;
    io_req.rd    = start && dev_sel && !acv_hit && !R_W;
    io_req.addr  = mar;
    io_req.wdata = mdr;
  end

  lc3_io_regs u_io_regs (
    .clk       (clk),
    .reset_n   (reset_n),
    .io_req    (io_req),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .ddr_valid (ddr_valid),
    .ddr_data  (ddr_data),
    .ddr_ready (ddr_ready),
    .kb_int    (kb_int),
    .run       (run),
    .rdata_c   (io_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      R         <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      R <= 1'b0;
      if (LD_MAR)            mar <= DATABUS;
      if (LD_MDR && !MIO_EN) mdr <= DATABUS;
      unique case (state)
        IDLE: begin
          if (MIO_EN) begin
            if (acv_hit) begin
              state <= DONE;
              R     <= 1'b1;
            end else if (dev_sel) begin
              state <= DONE;
              R     <= 1'b1;
              if (LD_MDR && !R_W) mdr <= io_rdata_c;
            end else begin
              // Memory port sees a snapshot of MAR/MDR/R_W for the whole access.
              state     <= MEM_WAIT;
              mem_req   <= 1'b1;
              mem_we    <= R_W;
              mem_addr  <= mar;
              mem_wdata <= mdr;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state   <= DONE;
            R       <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (LD_MDR && !mem_we) mdr <= mem_rdata;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_mem_if.sv
// Randomized self-checking bench for lc3_mem_if against a behavioural model.
module tb_lc3_mem_if;
  logic        clk, reset_n;
  logic [15:0] DATABUS;
  logic        LD_MAR, LD_MDR, MIO_EN, R_W, GateMDR, Priv_reg;
  wire  [15:0] mdr_bus;
  logic        R, ACV, kb_int, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, kbd_valid, ddr_valid, ddr_ready, run;
  logic [7:0]  kbd_data, ddr_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural state.
  logic [15:0] m_mar, m_mdr;
  logic        m_kb_rdy, m_kb_ie, m_dsr, m_mcr;
  logic [7:0]  m_kbdr, m_ddr;
  logic [15:0] m_mem [logic [15:0]];

  lc3_mem_if dut (
    .clk(clk), .reset_n(reset_n), .DATABUS(DATABUS), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .R_W(R_W), .GateMDR(GateMDR), .MDRbus_out(mdr_bus), .Priv_reg(Priv_reg),
    .R(R), .ACV(ACV), .kb_int(kb_int), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .kbd_valid(kbd_valid),
    .kbd_data(kbd_data), .ddr_valid(ddr_valid), .ddr_data(ddr_data), .ddr_ready(ddr_ready),
    .run(run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_dev(input logic [15:0] a);
    return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06) || (a == 16'hFFFE);
  endfunction

  function automatic logic acv_exp(input logic [15:0] a);
`ifdef LC3_ACV_EN
    return Priv_reg && ((a < 16'h3000) || (a >= 16'hFE00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] dev_rd(input logic [15:0] a);
    case (a)
      16'hFE00: return {m_kb_rdy, m_kb_ie, 14'h0000};
      16'hFE02: return {8'h00, m_kbdr};
      16'hFE04: return {m_dsr, 15'h0000};
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic dev_wr(input logic [15:0] a, input logic [15:0] d);
    case (a)
      16'hFE00: m_kb_ie = d[14];
      16'hFE06: begin m_ddr = d[7:0]; m_dsr = 1'b0; end
      16'hFFFE: m_mcr = d[15];
      default: ;
    endcase
  endtask

  task automatic model_reset;
    m_mar = 16'h0; m_mdr = 16'h0; m_kb_rdy = 1'b0; m_kb_ie = 1'b0;
    m_kbdr = 8'h00; m_ddr = 8'h00; m_dsr = 1'b1; m_mcr = 1'b1;
  endtask

  // One full controller-style access; the bench also plays the memory.
  task automatic access(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                        input int delay, input logic scramble, output logic [15:0] got);
    int cyc, req_cnt, exp_lat;
    logic got_r, acv_seen, exp_acv, exp_mem;
    DATABUS = addr; LD_MAR = 1'b1; tick; LD_MAR = 1'b0; m_mar = addr;
    if (wr) begin DATABUS = wdata; LD_MDR = 1'b1; tick; LD_MDR = 1'b0; m_mdr = wdata; end
    exp_acv = acv_exp(addr);
    exp_mem = !exp_acv && !is_dev(addr);
    exp_lat = exp_mem ? delay + 1 : 1;
    if (exp_mem && !wr && !m_mem.exists(addr)) m_mem[addr] = 16'($urandom);
    MIO_EN = 1'b1; R_W = wr; LD_MDR = !wr;
    cyc = 0; req_cnt = 0; got_r = 1'b0; acv_seen = 1'b0;
    while (!got_r && cyc < 64) begin
      tick; cyc++;
      if (R) begin
        got_r = 1'b1; acv_seen = ACV;
      end else if (mem_req) begin
        req_cnt++;
        checks++;
        if ({mem_addr, mem_we, mem_wdata} !== {addr, wr, m_mdr}) begin
          errors++;
          $display("FAIL mem_port got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h",
                   mem_addr, mem_we, mem_wdata, addr, wr, m_mdr);
        end
        if (scramble) begin DATABUS = 16'($urandom); LD_MAR = 1'b1; m_mar = DATABUS; end
        if (req_cnt == delay) begin
          mem_ready = 1'b1;
          mem_rdata = wr ? 16'($urandom) : m_mem[addr];
        end
      end
    end
    MIO_EN = 1'b0; LD_MDR = 1'b0; LD_MAR = 1'b0; mem_ready = 1'b0; R_W = 1'b0;
    checks++;
    if (!got_r) begin errors++; $display("FAIL r_timeout addr=%h got no R exp R within 64", addr); end
    checks++;
    if (cyc != exp_lat) begin errors++; $display("FAIL latency addr=%h got %0d exp %0d", addr, cyc, exp_lat); end
    checks++;
    if ((req_cnt > 0) != exp_mem) begin errors++; $display("FAIL mem_req_seen addr=%h got %0d exp %0d", addr, req_cnt > 0, exp_mem); end
    checks++;
    if (acv_seen !== exp_acv) begin errors++; $display("FAIL acv addr=%h got %b exp %b", addr, acv_seen, exp_acv); end
    if (exp_mem) begin
      if (wr) m_mem[addr] = m_mdr; else m_mdr = m_mem[addr];
    end else if (!exp_acv) begin
      if (wr) dev_wr(addr, m_mdr);
      else begin m_mdr = dev_rd(addr); if (addr == 16'hFE02) m_kb_rdy = 1'b0; end
    end
    tick;
    if (kbd_valid && !m_kb_rdy) begin m_kb_rdy = 1'b1; m_kbdr = kbd_data; end
    checks++;
    if ({R, ACV} !== 2'b00) begin errors++; $display("FAIL r_one_cycle addr=%h got R=%b ACV=%b exp 0 0", addr, R, ACV); end
    GateMDR = 1'b1; #1; got = mdr_bus; GateMDR = 1'b0;
    checks++;
    if (got !== m_mdr) begin errors++; $display("FAIL mdr addr=%h got %h exp %h", addr, got, m_mdr); end
  endtask

  task automatic test_reset;
    logic [15:0] got;
    checks++;
    if ({R, ACV, mem_req, kb_int, ddr_valid, run} !== 6'b000001) begin
      errors++; $display("FAIL reset_outputs got %b exp 000001", {R, ACV, mem_req, kb_int, ddr_valid, run});
    end
    checks++;
    if (ddr_data !== 8'h00) begin errors++; $display("FAIL reset_ddr_data got %h exp 00", ddr_data); end
    GateMDR = 1'b1; #1; got = mdr_bus; GateMDR = 1'b0;
    checks++;
    if (got !== 16'h0000) begin errors++; $display("FAIL reset_mdr got %h exp 0000", got); end
    access(16'hFE04, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'h8000) begin errors++; $display("FAIL reset_dsr got %h exp 8000", got); end
    access(16'hFE00, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'h0000) begin errors++; $display("FAIL reset_kbsr got %h exp 0000", got); end
  endtask

  task automatic test_mem_read;
    logic [15:0] got;
    m_mem[16'h3000] = 16'h1234;
    access(16'h3000, 1'b0, 16'h0, 3, 1'b0, got);
    checks++;
    if (got !== 16'h1234) begin errors++; $display("FAIL mem_read got %h exp 1234", got); end
    m_mem[16'h3001] = 16'h0F0F;
    access(16'h3001, 1'b0, 16'h0, 2, 1'b1, got);
  endtask

  task automatic test_mem_write;
    logic [15:0] got;
    access(16'h4000, 1'b1, 16'hBEEF, 3, 1'b0, got);
    checks++;
    if (got !== 16'hBEEF) begin errors++; $display("FAIL mem_write_mdr got %h exp BEEF", got); end
  endtask

  task automatic test_keyboard;
    logic [15:0] got;
    access(16'hFE00, 1'b1, 16'h4000, 0, 1'b0, got);
    kbd_data = 8'h41; kbd_valid = 1'b1; tick; kbd_valid = 1'b0;
    m_kb_rdy = 1'b1; m_kbdr = 8'h41;
    checks++;
    if (kb_int !== 1'b1) begin errors++; $display("FAIL kb_int_set got %b exp 1", kb_int); end
    kbd_data = 8'h77; kbd_valid = 1'b1; tick; kbd_valid = 1'b0;
    access(16'hFE00, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'hC000) begin errors++; $display("FAIL kbsr_full got %h exp C000", got); end
    access(16'hFE02, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'h0041) begin errors++; $display("FAIL kbdr_read got %h exp 0041", got); end
    checks++;
    if (kb_int !== 1'b0) begin errors++; $display("FAIL kb_int_clear got %b exp 0", kb_int); end
    access(16'hFE00, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'h4000) begin errors++; $display("FAIL kbsr_empty got %h exp 4000", got); end
    kbd_data = 8'h33; kbd_valid = 1'b1; tick; kbd_valid = 1'b0;
    m_kb_rdy = 1'b1; m_kbdr = 8'h33;
    kbd_data = 8'h5A; kbd_valid = 1'b1;
    access(16'hFE02, 1'b0, 16'h0, 0, 1'b0, got);
    kbd_valid = 1'b0;
    checks++;
    if (got !== 16'h0033) begin errors++; $display("FAIL kbdr_priority got %h exp 0033", got); end
    access(16'hFE02, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'h005A) begin errors++; $display("FAIL kbdr_next got %h exp 005A", got); end
    access(16'hFE00, 1'b1, 16'hFFFF, 0, 1'b0, got);
    access(16'hFE00, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'h4000) begin errors++; $display("FAIL kbsr_ie_only got %h exp 4000", got); end
  endtask

  task automatic test_display;
    logic [15:0] got;
    access(16'hFE06, 1'b1, 16'h0058, 0, 1'b0, got);
    checks++;
    if ({ddr_valid, ddr_data} !== {1'b1, 8'h58}) begin
      errors++; $display("FAIL ddr_write got valid=%b data=%h exp 1 58", ddr_valid, ddr_data);
    end
    access(16'hFE04, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'h0000) begin errors++; $display("FAIL dsr_busy got %h exp 0000", got); end
    ddr_ready = 1'b1; tick; ddr_ready = 1'b0; m_dsr = 1'b1;
    checks++;
    if (ddr_valid !== 1'b0) begin errors++; $display("FAIL ddr_handshake got %b exp 0", ddr_valid); end
    access(16'hFE04, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'h8000) begin errors++; $display("FAIL dsr_ready got %h exp 8000", got); end
    access(16'hFFFE, 1'b1, 16'h7FFF, 0, 1'b0, got);
    checks++;
    if (run !== m_mcr) begin errors++; $display("FAIL mcr_clear got %b exp %b", run, m_mcr); end
    access(16'hFFFE, 1'b1, 16'h8000, 0, 1'b0, got);
    checks++;
    if (run !== 1'b1) begin errors++; $display("FAIL mcr_set got %b exp 1", run); end
  endtask

  task automatic test_acv;
    logic [15:0] got;
    DATABUS = 16'hA5A5; LD_MDR = 1'b1; tick; LD_MDR = 1'b0; m_mdr = 16'hA5A5;
    Priv_reg = 1'b1;
    access(16'h0200, 1'b0, 16'h0, 2, 1'b0, got);
`ifdef LC3_ACV_EN
    checks++;
    if (got !== 16'hA5A5) begin errors++; $display("FAIL acv_mdr got %h exp A5A5", got); end
    access(16'hFE06, 1'b1, 16'h0041, 0, 1'b0, got);
    checks++;
    if (ddr_valid !== 1'b0) begin errors++; $display("FAIL acv_dev_write got %b exp 0", ddr_valid); end
`endif
    access(16'h3000, 1'b0, 16'h0, 1, 1'b0, got);
    Priv_reg = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [15:0] got;
    DATABUS = 16'h5000; LD_MAR = 1'b1; tick; LD_MAR = 1'b0;
    MIO_EN = 1'b1; R_W = 1'b0; LD_MDR = 1'b1;
    tick; tick;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_active got %b exp 1", mem_req); end
    reset_n = 1'b0; tick;
    checks++;
    if ({mem_req, R} !== 2'b00) begin errors++; $display("FAIL mid_reset got req=%b R=%b exp 0 0", mem_req, R); end
    reset_n = 1'b1; MIO_EN = 1'b0; LD_MDR = 1'b0;
    model_reset();
    GateMDR = 1'b1; #1; got = mdr_bus; GateMDR = 1'b0;
    checks++;
    if (got !== 16'h0000) begin errors++; $display("FAIL mid_mdr got %h exp 0000", got); end
    access(16'hFE04, 1'b0, 16'h0, 0, 1'b0, got);
    checks++;
    if (got !== 16'h8000) begin errors++; $display("FAIL mid_idle_dsr got %h exp 8000", got); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, d, got;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      while (is_dev(a)) a = 16'($urandom);
      if (i % 5 == 0) a = 16'h6000 + 16'(i % 3);
      d = 16'($urandom);
      access(a, 1'($urandom_range(0, 1)), d, $urandom_range(1, 4), 1'($urandom_range(0, 1)), got);
    end
  endtask

  initial begin
    reset_n = 1'b0; DATABUS = 16'h0; LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b0; R_W = 1'b0;
    GateMDR = 1'b0; Priv_reg = 1'b0; mem_rdata = 16'h0; mem_ready = 1'b0;
    kbd_valid = 1'b0; kbd_data = 8'h00; ddr_ready = 1'b0;
    model_reset();
    tick; tick;
    reset_n = 1'b1;
    test_reset();
    test_mem_read();
    test_mem_write();
    test_keyboard();
    test_display();
    test_acv();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
